// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and sync-character constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, MEASURE, STOP, DONE, ERR} autobaud_state_e;

    localparam logic [7:0] SyncChar     = 8'h55;
    localparam int         SyncFalls    = 5;
    localparam int         SyncSpanBits = 8;
endpackage

// File: rtl/uart_sync_edge.sv
// rtl/uart_sync_edge.sv - 2-flop synchroniser with registered rise/fall pulses
module uart_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // Reset to the idle-high line level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - recovers clocks-per-bit from a 0x55 sync character
import uart_pkg::*;

module uart_autobaud #(
    parameter int MinDivider     = 16,
    parameter int MaxDivider     = 4096,
    parameter int DefaultDivider = 1000,
    parameter int OverSample     = 8,
    parameter int DW             = $clog2(MaxDivider + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx,
    input  logic          i_enable,
    output logic [DW-1:0] o_divider,
    output logic [DW-1:0] o_os_divider,
    output logic          o_valid,
    output logic          o_error,
    output logic          o_busy
);
    localparam int IcMax      = 2 * MaxDivider + 1;
    localparam int IcW        = $clog2(IcMax + 1);
    localparam int SumW       = $clog2(SyncSpanBits * MaxDivider + SyncSpanBits);
    localparam int RoundShift = $clog2(SyncSpanBits);

    logic w_line;
    logic w_rise;
    logic w_fall;

    autobaud_state_e r_state;
    logic [IcW-1:0]  r_ic;
    logic [IcW-1:0]  r_i0;
    logic [2:0]      r_cnt;
    logic [SumW-1:0] r_sum;
    logic [DW-1:0]   r_divider;
    logic [DW-1:0]   r_os_divider;
    logic            r_valid;
    logic            r_error;
    logic            r_busy;

    logic [IcW-1:0]  w_diff;
    logic [IcW-1:0]  w_stop_bound;
    logic            w_sat;
    logic            w_short;
    logic            w_off_tol;
    logic [DW-1:0]   w_new_div;

    uart_sync_edge u_sync_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_rx),
        .o_level (w_line),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_sat        = (r_ic == IcW'(IcMax));
    assign w_short      = (r_ic < IcW'(2 * MinDivider));
    assign w_diff       = (r_ic >= r_i0) ? (r_ic - r_i0) : (r_i0 - r_ic);
    // The first interval is the reference, so it is never tolerance-checked.
    assign w_off_tol    = (r_cnt != 3'd1) && (w_diff > (r_i0 >> 2));
    assign w_stop_bound = (r_i0 >> 1) + (r_i0 >> 2);
    assign w_new_div    = DW'((r_sum + SumW'(SyncSpanBits / 2)) >> RoundShift);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_ic         <= IcW'(1);
            r_i0         <= '0;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_divider    <= DW'(DefaultDivider);
            r_os_divider <= DW'(DefaultDivider / OverSample);
            r_valid      <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (!w_sat) begin
                r_ic <= r_ic + IcW'(1);
            end
            if (!i_enable) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_line) begin
                            r_state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (w_fall) begin
                            r_state <= MEASURE;
                            r_busy  <= 1'b1;
                            r_cnt   <= 3'd1;
                            r_ic    <= IcW'(1);
                            r_sum   <= '0;
                        end
                    end
                    MEASURE: begin
                        if (w_sat) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (w_fall) begin
                            r_ic <= IcW'(1);
                            if (w_short || w_off_tol) begin
                                r_state <= ERR;
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_sum <= r_sum + SumW'(r_ic);
                                if (r_cnt == 3'd1) begin
                                    r_i0 <= r_ic;
                                end
                                if (r_cnt == 3'(SyncFalls - 1)) begin
                                    r_state <= STOP;
                                end else begin
                                    r_cnt <= r_cnt + 3'd1;
                                end
                            end
                        end
                    end
                    STOP: begin
                        if (w_rise && (r_ic <= w_stop_bound)) begin
                            r_state      <= DONE;
                            r_busy       <= 1'b0;
                            r_valid      <= 1'b1;
                            r_divider    <= w_new_div;
                            r_os_divider <= w_new_div / DW'(OverSample);
                        end else if (r_ic > w_stop_bound) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    DONE:    r_state <= ARMED;
                    ERR:     r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_divider    = r_divider;
    assign o_os_divider = r_os_divider;
    assign o_valid      = r_valid;
    assign o_error      = r_error;
    assign o_busy       = r_busy;
endmodule
